// File: rtl/mpu_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_common (package)
//  Brief    : Shared MPU sizing, ACT entry layout and deallocator enums.
//  Revision : 1.0
// ============================================================================
package mpu_common;

    localparam int CORE_COUNT       = 4;
    localparam int CORE_ID_WIDTH    = 2;
    localparam int BLOCK_COUNT      = 16;
    localparam int BLOCK_COUNT_BITS = 4;
    localparam int ADDR_WIDTH       = 16;
    localparam int REGION_SHIFT     = 8;

    typedef struct packed {
        logic                        valid;
        logic [CORE_COUNT-1:0]       write_mask;
        logic [CORE_COUNT-1:0]       read_mask;
        logic [CORE_ID_WIDTH-1:0]    owner;
        logic [BLOCK_COUNT_BITS-1:0] res_id;
    } entry_t;

    typedef enum logic [2:0] {
        FREE_NO_ERROR      = 3'd0,
        FREE_INVALID_ADDR  = 3'd1,
        FREE_NOT_ALLOCATED = 3'd2,
        FREE_NOT_OWNER     = 3'd3,
        FREE_NOT_BASE      = 3'd4
    } mfree_error_t;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_HEAD  = 4'd1,
        CHECK_HEAD = 4'd2,
        LOAD_PREV  = 4'd3,
        CHECK_PREV = 4'd4,
        WIPE       = 4'd5,
        LOAD_NEXT  = 4'd6,
        CHECK_NEXT = 4'd7,
        RELEASE    = 4'd8,
        RESULT     = 4'd9
    } mfree_state_t;

endpackage
`default_nettype wire

// File: rtl/mfree.sv
`default_nettype none
// ============================================================================
//  Module   : mfree
//  Brief    : MPU deallocation engine; validates a free request against the
//             ACT, wipes the region's entries and returns its reservation id.
//  Revision : 1.0
// ============================================================================
module mfree
    import mpu_common::*;
#(
    parameter int CORE_COUNT       = mpu_common::CORE_COUNT,
    parameter int CORE_ID_WIDTH    = mpu_common::CORE_ID_WIDTH,
    parameter int BLOCK_COUNT      = mpu_common::BLOCK_COUNT,
    parameter int BLOCK_COUNT_BITS = mpu_common::BLOCK_COUNT_BITS,
    parameter int ADDR_WIDTH       = mpu_common::ADDR_WIDTH,
    parameter int REGION_SHIFT     = mpu_common::REGION_SHIFT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic [CORE_ID_WIDTH-1:0]    core_id,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  entry_t                      act_rdata,
    output logic                        act_cs,
    output logic                        act_we,
    output logic [BLOCK_COUNT_BITS-1:0] act_addr,
    output entry_t                      act_wdata,
    output logic [BLOCK_COUNT_BITS-1:0] reservation_id_out,
    output logic                        reservation_enqueue,
    output logic [BLOCK_COUNT_BITS:0]   blocks_freed,
    output logic                        rdy,
    output logic                        bsy,
    output mfree_error_t                err
);

    localparam int                      IDX_W     = ADDR_WIDTH - REGION_SHIFT;
    localparam logic [IDX_W-1:0]        IDX_LIMIT = IDX_W'(BLOCK_COUNT);
    localparam logic [BLOCK_COUNT_BITS:0] CUR_END = (BLOCK_COUNT_BITS+1)'(BLOCK_COUNT);

    // The entry layout is fixed by the package, so the port parameters must agree with it.
    if (CORE_COUNT != mpu_common::CORE_COUNT || CORE_ID_WIDTH != mpu_common::CORE_ID_WIDTH ||
        BLOCK_COUNT_BITS != mpu_common::BLOCK_COUNT_BITS || IDX_W <= BLOCK_COUNT_BITS) begin : g_cfg_check
        $error("mfree: parameters inconsistent with mpu_common");
    end

    mfree_state_t                  state, state_nx;
    logic [CORE_ID_WIDTH-1:0]      core_reg, core_reg_nx;
    logic [BLOCK_COUNT_BITS-1:0]   res_reg, res_reg_nx;
    logic [BLOCK_COUNT_BITS:0]     cur, cur_nx;

    logic                          act_cs_nx, act_we_nx, enq_nx, rdy_nx, bsy_nx;
    logic [BLOCK_COUNT_BITS-1:0]   act_addr_nx, res_out_nx;
    entry_t                        act_wdata_nx;
    logic [BLOCK_COUNT_BITS:0]     freed_nx;
    mfree_error_t                  err_nx;

    logic [IDX_W-1:0]              req_idx;
    logic                          misaligned;
    logic [BLOCK_COUNT_BITS-1:0]   cur_idx;
    logic                          run_ends;
    logic                          unused_mask_bits;

    assign req_idx    = base_addr[ADDR_WIDTH-1:REGION_SHIFT];
    assign misaligned = |base_addr[REGION_SHIFT-1:0];
    assign cur_idx    = cur[BLOCK_COUNT_BITS-1:0];
    // At the table end the read data belongs to a wrapped address and must be ignored.
    assign run_ends   = (cur == CUR_END) || !act_rdata.valid || (act_rdata.res_id != res_reg);
    assign unused_mask_bits = ^{act_rdata.write_mask, act_rdata.read_mask};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            core_reg            <= '0;
            res_reg             <= '0;
            cur                 <= '0;
            act_cs              <= 1'b0;
            act_we              <= 1'b0;
            act_addr            <= '0;
            act_wdata           <= '0;
            reservation_id_out  <= '0;
            reservation_enqueue <= 1'b0;
            blocks_freed        <= '0;
            rdy                 <= 1'b0;
            bsy                 <= 1'b0;
            err                 <= FREE_NO_ERROR;
        end else begin
            state               <= state_nx;
            core_reg            <= core_reg_nx;
            res_reg             <= res_reg_nx;
            cur                 <= cur_nx;
            act_cs              <= act_cs_nx;
            act_we              <= act_we_nx;
            act_addr            <= act_addr_nx;
            act_wdata           <= act_wdata_nx;
            reservation_id_out  <= res_out_nx;
            reservation_enqueue <= enq_nx;
            blocks_freed        <= freed_nx;
            rdy                 <= rdy_nx;
            bsy                 <= bsy_nx;
            err                 <= err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        core_reg_nx  = core_reg;
        res_reg_nx   = res_reg;
        cur_nx       = cur;
        act_cs_nx    = act_cs;
        act_we_nx    = act_we;
        act_addr_nx  = act_addr;
        act_wdata_nx = act_wdata;
        res_out_nx   = reservation_id_out;
        enq_nx       = reservation_enqueue;
        freed_nx     = blocks_freed;
        rdy_nx       = rdy;
        bsy_nx       = bsy;
        err_nx       = err;

        case (state)
            IDLE: begin
                if (cs) begin
                    core_reg_nx = core_id;
                    if (misaligned || req_idx >= IDX_LIMIT) begin
                        err_nx   = FREE_INVALID_ADDR;
                        rdy_nx   = 1'b1;
                        state_nx = RESULT;
                    end else begin
                        bsy_nx      = 1'b1;
                        act_cs_nx   = 1'b1;
                        act_we_nx   = 1'b0;
                        act_addr_nx = req_idx[BLOCK_COUNT_BITS-1:0];
                        cur_nx      = {1'b0, req_idx[BLOCK_COUNT_BITS-1:0]};
                        state_nx    = LOAD_HEAD;
                    end
                end
            end
            LOAD_HEAD: state_nx = CHECK_HEAD;
            CHECK_HEAD: begin
                if (!act_rdata.valid || act_rdata.owner != core_reg) begin
                    err_nx    = act_rdata.valid ? FREE_NOT_OWNER : FREE_NOT_ALLOCATED;
                    rdy_nx    = 1'b1;
                    act_cs_nx = 1'b0;
                    state_nx  = RESULT;
                end else begin
                    res_reg_nx = act_rdata.res_id;
                    if (cur_idx == '0) begin
                        act_we_nx    = 1'b1;
                        act_addr_nx  = cur_idx;
                        act_wdata_nx = '0;
                        state_nx     = WIPE;
                    end else begin
                        act_addr_nx = cur_idx - 1'b1;
                        state_nx    = LOAD_PREV;
                    end
                end
            end
            LOAD_PREV: state_nx = CHECK_PREV;
            CHECK_PREV: begin
                // A live predecessor with the same id means the address is mid-region.
                if (act_rdata.valid && act_rdata.res_id == res_reg) begin
                    err_nx    = FREE_NOT_BASE;
                    rdy_nx    = 1'b1;
                    act_cs_nx = 1'b0;
                    state_nx  = RESULT;
                end else begin
                    act_we_nx    = 1'b1;
                    act_addr_nx  = cur_idx;
                    act_wdata_nx = '0;
                    state_nx     = WIPE;
                end
            end
            WIPE: begin
                act_we_nx   = 1'b0;
                act_addr_nx = cur_idx + 1'b1;
                cur_nx      = cur + 1'b1;
                freed_nx    = blocks_freed + 1'b1;
                state_nx    = LOAD_NEXT;
            end
            LOAD_NEXT: state_nx = CHECK_NEXT;
            CHECK_NEXT: begin
                if (run_ends) begin
                    act_cs_nx  = 1'b0;
                    enq_nx     = 1'b1;
                    res_out_nx = res_reg;
                    state_nx   = RELEASE;
                end else begin
                    act_we_nx    = 1'b1;
                    act_addr_nx  = cur_idx;
                    act_wdata_nx = '0;
                    state_nx     = WIPE;
                end
            end
            RELEASE: begin
                enq_nx   = 1'b0;
                rdy_nx   = 1'b1;
                state_nx = RESULT;
            end
            RESULT: begin
                rdy_nx    = 1'b0;
                bsy_nx    = 1'b0;
                err_nx    = FREE_NO_ERROR;
                freed_nx  = '0;
                act_cs_nx = 1'b0;
                act_we_nx = 1'b0;
                state_nx  = IDLE;
            end
            default: begin
                state_nx     = IDLE;
                core_reg_nx  = '0;
                res_reg_nx   = '0;
                cur_nx       = '0;
                act_cs_nx    = 1'b0;
                act_we_nx    = 1'b0;
                act_addr_nx  = '0;
                act_wdata_nx = '0;
                res_out_nx   = '0;
                enq_nx       = 1'b0;
                freed_nx     = '0;
                rdy_nx       = 1'b0;
                bsy_nx       = 1'b0;
                err_nx       = FREE_NO_ERROR;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mfree.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfree
//  Brief    : Self-checking bench for mfree with an ACT memory and a
//             region-level reference model of the free operation.
//  Revision : 1.0
// ============================================================================
module tb_mfree;
    import mpu_common::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        cs;
    logic [CORE_ID_WIDTH-1:0]    core_id;
    logic [ADDR_WIDTH-1:0]       base_addr;
    entry_t                      act_rdata;
    logic                        act_cs;
    logic                        act_we;
    logic [BLOCK_COUNT_BITS-1:0] act_addr;
    entry_t                      act_wdata;
    logic [BLOCK_COUNT_BITS-1:0] reservation_id_out;
    logic                        reservation_enqueue;
    logic [BLOCK_COUNT_BITS:0]   blocks_freed;
    logic                        rdy;
    logic                        bsy;
    mfree_error_t                err;

    always #5 clk = ~clk;

    mfree dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cs                  (cs),
        .core_id             (core_id),
        .base_addr           (base_addr),
        .act_rdata           (act_rdata),
        .act_cs              (act_cs),
        .act_we              (act_we),
        .act_addr            (act_addr),
        .act_wdata           (act_wdata),
        .reservation_id_out  (reservation_id_out),
        .reservation_enqueue (reservation_enqueue),
        .blocks_freed        (blocks_freed),
        .rdy                 (rdy),
        .bsy                 (bsy),
        .err                 (err)
    );

    // Single-port ACT: registered read, write on the edge that sees act_we.
    entry_t mem      [BLOCK_COUNT];
    entry_t init_mem [BLOCK_COUNT];
    entry_t exp_tbl  [BLOCK_COUNT];
    logic   load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < BLOCK_COUNT; i++) mem[i] <= init_mem[i];
        end else if (act_cs) begin
            if (act_we) mem[act_addr] <= act_wdata;
            else        act_rdata     <= mem[act_addr];
        end
    end

    int compared   = 0;
    int mismatched = 0;

    mfree_error_t exp_err;
    int           exp_n;
    int           exp_edge;
    int           exp_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic entry_t mk(input bit v, input int own, input int rid);
        entry_t e;
        e            = '0;
        e.valid      = v;
        e.write_mask = CORE_COUNT'($urandom);
        e.read_mask  = CORE_COUNT'($urandom);
        e.owner      = CORE_ID_WIDTH'(own);
        e.res_id     = BLOCK_COUNT_BITS'(rid);
        return e;
    endfunction

    task automatic load_table();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < BLOCK_COUNT; i++) init_mem[i] = mk(1'b0, 0, 0);
    endtask

    // Region-level model: validate, then clear the maximal run of same-id entries.
    task automatic model(input int c, input int b);
        int idx;
        int r;
        for (int i = 0; i < BLOCK_COUNT; i++) exp_tbl[i] = init_mem[i];
        exp_n = 0;
        exp_id = 0;
        idx = b / (1 << REGION_SHIFT);
        if ((b % (1 << REGION_SHIFT)) != 0 || idx >= BLOCK_COUNT) begin
            exp_err = FREE_INVALID_ADDR; exp_edge = 0;
        end else if (!init_mem[idx].valid) begin
            exp_err = FREE_NOT_ALLOCATED; exp_edge = 2;
        end else if (int'(init_mem[idx].owner) != c) begin
            exp_err = FREE_NOT_OWNER; exp_edge = 2;
        end else begin
            r = int'(init_mem[idx].res_id);
            if (idx > 0 && init_mem[idx-1].valid && int'(init_mem[idx-1].res_id) == r) begin
                exp_err = FREE_NOT_BASE; exp_edge = 4;
            end else begin
                exp_err = FREE_NO_ERROR;
                exp_id  = r;
                for (int i = idx; i < BLOCK_COUNT; i++) begin
                    if (!init_mem[i].valid || int'(init_mem[i].res_id) != r) break;
                    exp_tbl[i] = '0;
                    exp_n++;
                end
                exp_edge = (idx > 0 ? 5 : 3) + 3 * exp_n;
            end
        end
    endtask

    task automatic do_free(input int c, input int b);
        int   edge_n = 0;
        bit   got = 0;
        bit   saw_cs = 0;
        int   enq_cnt = 0;
        int   enq_id = 0;
        int   got_err = 0;
        int   got_n = 0;
        logic bsy0;
        model(c, b);
        @(negedge clk);
        cs = 1'b1; core_id = CORE_ID_WIDTH'(c); base_addr = ADDR_WIDTH'(b);
        @(posedge clk); #1;
        cs = 1'b0;
        bsy0 = bsy;
        while (!got && edge_n <= 200) begin
            if (act_cs) saw_cs = 1;
            if (reservation_enqueue) begin enq_cnt++; enq_id = int'(reservation_id_out); end
            if (rdy) begin
                got = 1; got_err = int'(err); got_n = int'(blocks_freed);
            end else begin
                @(posedge clk); #1; edge_n++;
            end
        end
        check("rdy_seen", 32'(got), 32'd1);
        check("err", 32'(got_err), 32'(exp_err));
        check("latency", 32'(edge_n), 32'(exp_edge));
        check("blocks_freed", 32'(got_n), 32'(exp_n));
        check("enq_count", 32'(enq_cnt), (exp_err == FREE_NO_ERROR) ? 32'd1 : 32'd0);
        check("enq_id", 32'(enq_id), 32'(exp_id));
        check("bsy_accept", 32'(bsy0), (exp_err == FREE_INVALID_ADDR) ? 32'd0 : 32'd1);
        if (exp_err == FREE_INVALID_ADDR) check("act_cs_idle", 32'(saw_cs), 32'd0);
        @(posedge clk); #1;
        check("rdy_drop", 32'(rdy), 32'd0);
        check("bsy_drop", 32'(bsy), 32'd0);
        check("err_clear", 32'(err), 32'(FREE_NO_ERROR));
        for (int i = 0; i < BLOCK_COUNT; i++) check($sformatf("act[%0d]", i), 32'(mem[i]), 32'(exp_tbl[i]));
        for (int i = 0; i < BLOCK_COUNT; i++) init_mem[i] = exp_tbl[i];
    endtask

    task automatic setup_basic();
        clear_table();
        for (int i = 4; i <= 6; i++) init_mem[i] = mk(1'b1, 2, 3);
        init_mem[3] = mk(1'b0, 2, 3);
        init_mem[7] = mk(1'b1, 1, 9);
        load_table();
    endtask

    task automatic rand_table();
        int i = 0;
        int len;
        int own;
        int rid;
        while (i < BLOCK_COUNT) begin
            if ($urandom_range(0, 3) == 0) begin
                init_mem[i] = mk(1'b0, $urandom_range(0, 3), $urandom_range(0, 15));
                i++;
            end else begin
                len = $urandom_range(1, 4);
                own = $urandom_range(0, CORE_COUNT - 1);
                rid = $urandom_range(0, 3);
                for (int k = 0; k < len && i < BLOCK_COUNT; k++) begin
                    init_mem[i] = mk(1'b1, own, rid);
                    i++;
                end
            end
        end
        load_table();
    endtask

    initial begin
        int mode;
        int idx;
        int c;
        bit seen;
        rst_n = 1'b0; cs = 1'b0; core_id = '0; base_addr = '0; load = 1'b0;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({act_cs, act_we, act_addr, act_wdata, reservation_id_out,
              reservation_enqueue, blocks_freed, rdy, bsy, err}), 32'd0);
        rst_n = 1'b1;

        setup_basic();
        do_free(2, 'h0400);
        do_free(2, 'h0410);
        setup_basic();
        do_free(1, 'h0400);
        do_free(2, 'h0500);

        clear_table();
        init_mem[14] = mk(1'b1, 0, 5);
        init_mem[15] = mk(1'b1, 0, 5);
        init_mem[0]  = mk(1'b1, 0, 5);
        load_table();
        do_free(0, 'h0E00);
        do_free(0, 'h0000);
        do_free(3, 'h1000);

        // Reset landing on the write of entry 5 abandons the walk.
        setup_basic();
        @(negedge clk);
        cs = 1'b1; core_id = 2'd2; base_addr = 16'h0400;
        @(posedge clk); #1;
        cs = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        check("wipe5_we", 32'({act_we, act_addr}), 32'({1'b1, 4'd5}));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", 32'({act_cs, act_we, act_addr, act_wdata, reservation_id_out,
              reservation_enqueue, blocks_freed, rdy, bsy, err}), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (reservation_enqueue || rdy || bsy) seen = 1;
        end
        check("midreset_quiet", 32'(seen), 32'd0);
        check("midreset_e4", 32'(mem[4]), 32'd0);
        check("midreset_e6", 32'(mem[6]), 32'(init_mem[6]));
        check("midreset_e7", 32'(mem[7]), 32'(init_mem[7]));
        setup_basic();
        do_free(2, 'h0400);

        for (int n = 0; n < 40; n++) begin
            if (n % 4 == 0) rand_table();
            mode = $urandom_range(0, 7);
            idx  = $urandom_range(0, BLOCK_COUNT - 1);
            c    = ($urandom_range(0, 1) == 0) ? int'(init_mem[idx].owner) : $urandom_range(0, 3);
            if (mode == 6)      do_free(c, idx * 256 + $urandom_range(1, 255));
            else if (mode == 7) do_free(c, $urandom_range(BLOCK_COUNT, 255) * 256);
            else                do_free(c, idx * 256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfree.md
Name: mfree

Overview:
- Deallocation engine for the MPU; the counterpart of the allocator.
- Takes a free request (requesting core, region base address) and validates it against the access control table (ACT): base alignment, ownership, and that the address is the region head.
- Invalidates every contiguous ACT entry that carries the region's reservation id, then returns that id to the reservation counter through an enqueue pulse.
- Shares the single-port ACT with the allocator; an external arbiter grants the ACT while bsy is high.

Parameters:
CORE_COUNT, mpu_common::CORE_COUNT, number of cores (mask width)
CORE_ID_WIDTH, mpu_common::CORE_ID_WIDTH, core id width
BLOCK_COUNT, mpu_common::BLOCK_COUNT, ACT entries / memory blocks
BLOCK_COUNT_BITS, mpu_common::BLOCK_COUNT_BITS, log2(BLOCK_COUNT)
ADDR_WIDTH, mpu_common::ADDR_WIDTH, byte address width
REGION_SHIFT, mpu_common::REGION_SHIFT, log2(block size in bytes)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cs  in  1  request strobe; sampled only in IDLE
core_id  in  CORE_ID_WIDTH  requesting core
base_addr  in  ADDR_WIDTH  base address of the region to free
act_rdata  in  entry_t  ACT read data; valid the cycle after the ACT samples act_addr
act_cs  out  1  ACT select
act_we  out  1  ACT write enable
act_addr  out  BLOCK_COUNT_BITS  ACT index
act_wdata  out  entry_t  ACT write data
reservation_id_out  out  BLOCK_COUNT_BITS  id being returned
reservation_enqueue  out  1  one-cycle pulse returning reservation_id_out
blocks_freed  out  BLOCK_COUNT_BITS+1  entries invalidated; valid while rdy
rdy  out  1  one-cycle result strobe
bsy  out  1  high from request accept through the RESULT cycle
err  out  mfree_error_t  result code; valid while rdy

Behaviour:
- Reset is synchronous. state=IDLE. The following are all 0 / FREE_NO_ERROR: rdy, bsy, err, act_cs, act_we, act_addr, act_wdata, reservation_enqueue, reservation_id_out, blocks_freed. Reset mid-operation abandons the walk; entries already cleared stay cleared and no enqueue occurs.
- All outputs are registered. ACT timing: an address registered at edge k is sampled by the ACT at edge k+1, and its data is used in the following cycle.
- IDLE, cs=1: latch core_id. Compute idx = base_addr>>REGION_SHIFT.
  - If base_addr[REGION_SHIFT-1:0]!=0 or idx>=BLOCK_COUNT: set err=FREE_INVALID_ADDR, rdy=1, go to RESULT. The ACT is not touched.
  - Otherwise: bsy=1, act_cs=1, act_we=0, act_addr=idx, cur=idx, go to LOAD_HEAD.
- LOAD_HEAD -> CHECK_HEAD.
- CHECK_HEAD:
  - If !valid: err=FREE_NOT_ALLOCATED.
  - Else if owner!=core_id_reg: err=FREE_NOT_OWNER.
  - Either error goes to RESULT with rdy=1.
  - Otherwise latch res_reg=act_rdata.res_id. If idx==0, go to WIPE with act_we=1, act_addr=cur, act_wdata='0. Else act_addr=idx-1, go to LOAD_PREV.
- LOAD_PREV -> CHECK_PREV.
- CHECK_PREV:
  - If valid && res_id==res_reg: err=FREE_NOT_BASE, go to RESULT.
  - Else go to WIPE, issuing the write as above.
- WIPE: the write is on the bus this cycle. Then act_we=0, act_addr=cur+1, cur++, blocks_freed++, go to LOAD_NEXT.
- LOAD_NEXT -> CHECK_NEXT.
- CHECK_NEXT:
  - If cur==BLOCK_COUNT, or !valid, or res_id!=res_reg: act_cs=0, reservation_enqueue=1, reservation_id_out=res_reg, go to RELEASE.
  - Else issue the write and go to WIPE.
  - cur is BLOCK_COUNT_BITS+1 wide; no wrap at the table end. When cur==BLOCK_COUNT, act_rdata is ignored.
- RELEASE: reservation_enqueue=0, rdy=1, go to RESULT.
- RESULT:
  - rdy high this cycle only. Then rdy=0, bsy=0, err=FREE_NO_ERROR, blocks_freed=0, act_cs=0, act_we=0, go to IDLE.
  - No partial frees: any error is detected before the first write.
- cs while not IDLE is ignored. The default state recovers to IDLE with all outputs cleared.
- Latency, counted from the edge that samples cs, N = blocks freed:
  - Success: rdy rises at edge 5+3N (idx>0) or 3+3N (idx==0).
  - Errors: FREE_INVALID_ADDR at edge 0; head error at edge 2; FREE_NOT_BASE at edge 4.
- A region that fills the table to its end is freed up to index BLOCK_COUNT-1 and then terminates normally.

Decomposition:
- mpu_common package gains:
  - mfree_error_t {FREE_NO_ERROR, FREE_INVALID_ADDR, FREE_NOT_ALLOCATED, FREE_NOT_OWNER, FREE_NOT_BASE}.
  - mfree_state_t {IDLE, LOAD_HEAD, CHECK_HEAD, LOAD_PREV, CHECK_PREV, WIPE, LOAD_NEXT, CHECK_NEXT, RELEASE, RESULT}.
- entry_t {valid, write_mask, read_mask, owner, res_id} is reused unchanged from the package.
- Single flat module; no sub-module is warranted.

Test Plan:
- Setup: BLOCK_COUNT=16, REGION_SHIFT=8, ACT entries 4..6 valid with owner=2, res_id=3, entry 3 invalid.
  - core 2, base 0x0400 -> entries 4..6 cleared to '0, entry 7 untouched, blocks_freed=3, err=NO_ERROR, enqueue pulse with id=3, rdy at edge 14.
- base 0x0410 -> FREE_INVALID_ADDR at edge 0, act_cs never asserted.
- Same setup, core 1, base 0x0400 -> FREE_NOT_OWNER at edge 2; ACT unchanged, no enqueue.
- Same setup, core 2, base 0x0500 -> FREE_NOT_BASE at edge 4; no writes.
- Entries 14..15 valid, res_id=5, owner=0; core 0, base 0x0E00 -> both cleared, blocks_freed=2, terminates at cur=16 without wrap, enqueue id=5.
- Reset asserted during the WIPE of entry 5 in the first scenario -> all outputs 0 next cycle, state IDLE, no enqueue; entry 4 stays cleared.
